seq_div_16by8: RTL and testbench

Sequential unsigned restoring divider: the inverse of the 8x8 multiplier path. It takes a 2N-bit dividend, such as a full multiplier product, and an N-bit divisor. It returns an N-bit quotient and an N-bit remainder after N iteration cycles. The block sits beside the multiplier in the arithmetic datapath and uses a start/busy/done handshake with explicit divide-by-zero and quotient-overflow detection.

---
 rtl/seq_div_16by8.sv | 111 +++++++++++
 tb/tb_seq_div_16by8.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_div_16by8.sv
// Sequential unsigned restoring divider: 2N-bit dividend / N-bit divisor -> N-bit quotient and
// remainder in N iteration cycles, with divide-by-zero and quotient-overflow detection.
module seq_div_16by8 #(
    parameter int unsigned N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StErr, StDone} state_e;

    state_e        state;
    logic [N:0]    rem_acc;
    logic [N-1:0]  quo_acc;
    logic [N-1:0]  dvsr;
    logic [CW-1:0] count;
    logic          err_zero;

    logic [N:0]    rem_shift;
    logic [N+1:0]  trial;
    logic          fits;
    logic [N:0]    rem_next;
    logic [N-1:0]  quo_next;
    logic          last;

    // One restoring step: shift {R,Q} left, subtract divisor, keep result only if non-negative.
    always_comb begin
        rem_shift = {rem_acc[N-1:0], quo_acc[N-1]};
        trial     = {1'b0, rem_shift} - {2'b00, dvsr};
        fits      = ~trial[N+1];
        rem_next  = fits ? trial[N:0] : rem_shift;
        quo_next  = {quo_acc[N-2:0], fits};
        last      = (count == CW'(N - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            rem_acc     <= '0;
            quo_acc     <= '0;
            dvsr        <= '0;
            count       <= '0;
            err_zero    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle, StDone: begin
                    state <= StIdle;
                    if (start) begin
                        dvsr <= divisor;
                        busy <= 1'b1;
                        if (divisor == '0) begin
                            err_zero <= 1'b1;
                            state    <= StErr;
                        end else if (dividend[2*N-1:N] >= divisor) begin
                            err_zero <= 1'b0;
                            state    <= StErr;
                        end else begin
                            rem_acc <= {1'b0, dividend[2*N-1:N]};
                            quo_acc <= dividend[N-1:0];
                            count   <= '0;
                            state   <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    rem_acc <= rem_next;
                    quo_acc <= quo_next;
                    count   <= count + CW'(1);
                    if (last) begin
                        state       <= StDone;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= quo_next;
                        remainder   <= rem_next[N-1:0];
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                StErr: begin
                    state       <= StDone;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    quotient    <= '1;
                    remainder   <= '0;
                    div_by_zero <= err_zero;
                    overflow    <= ~err_zero;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_16by8.sv
// Self-checking bench for seq_div_16by8: directed vector table, hand-written multi-cycle
// sequences (busy-start, mid-op reset, back-to-back) and a randomized sweep against a model.
module tb_seq_div_16by8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        busy, done;
    logic [7:0]  quotient, remainder;
    logic        div_by_zero, overflow;

    int nchecks = 0;
    int nerr = 0;

    seq_div_16by8 #(.N(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dd;
        logic [7:0]  dv;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        dz;
        logic        ov;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Launch one op; lat = edges from E0 until done is seen (capped at 20), bcnt = busy cycles.
    task automatic do_op(input logic [15:0] dd, input logic [7:0] dv,
                         output int lat, output int bcnt);
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        bcnt  = busy ? 1 : 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bcnt++;
        end
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat, bcnt, extra, ndone;
        logic [15:0] rdd;
        logic [7:0]  rdv, eq, er;
        logic        edz, eov;
        int          elat;

        vecs[0] = '{16'd1000,  8'd7,   8'd142, 8'd6, 1'b0, 1'b0, 8};
        vecs[1] = '{16'hFE01,  8'd255, 8'd255, 8'd0, 1'b0, 1'b0, 8};
        vecs[2] = '{16'h00FF,  8'd1,   8'd255, 8'd0, 1'b0, 1'b0, 8};
        vecs[3] = '{16'd1234,  8'd0,   8'hFF,  8'd0, 1'b1, 1'b0, 1};
        vecs[4] = '{16'd1000,  8'd7,   8'd142, 8'd6, 1'b0, 1'b0, 8};
        vecs[5] = '{16'h0500,  8'd5,   8'hFF,  8'd0, 1'b0, 1'b1, 1};
        vecs[6] = '{16'h04FF,  8'd5,   8'd255, 8'd4, 1'b0, 1'b0, 8};
        vecs[7] = '{16'd200,   8'd9,   8'd22,  8'd2, 1'b0, 1'b0, 8};
        vecs[8] = '{16'd0,     8'd3,   8'd0,   8'd0, 1'b0, 1'b0, 8};
        vecs[9] = '{16'hFFFE,  8'd255, 8'hFF,  8'd0, 1'b0, 1'b1, 1};

        // Reset state
        #12;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset quotient", quotient, 0);
        check("reset remainder", remainder, 0);
        check("reset div_by_zero", div_by_zero, 0);
        check("reset overflow", overflow, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].dd, vecs[i].dv, lat, bcnt);
            check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d busy cycles", i), bcnt, vecs[i].lat);
            check($sformatf("vec%0d quotient", i), quotient, vecs[i].q);
            check($sformatf("vec%0d remainder", i), remainder, vecs[i].r);
            check($sformatf("vec%0d div_by_zero", i), div_by_zero, vecs[i].dz);
            check($sformatf("vec%0d overflow", i), overflow, vecs[i].ov);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d done one cycle", i), done, 0);
            check($sformatf("vec%0d quotient holds", i), quotient, vecs[i].q);
        end

        // Start pulsed at E0+3 with other operands is ignored
        @(negedge clk);
        dividend = 16'd1000;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        dividend = 16'd500;
        divisor  = 8'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat);
        check("ignored start latency", lat + 3, 8);
        check("ignored start quotient", quotient, 142);
        check("ignored start remainder", remainder, 6);

        // Reset during CALC: immediate zeroed outputs, no done afterwards
        @(negedge clk);
        dividend = 16'd1000;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midreset busy", busy, 0);
        check("midreset quotient", quotient, 0);
        check("midreset remainder", remainder, 0);
        check("midreset flags", {div_by_zero, overflow}, 0);
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("midreset no done", ndone, 0);
        check("midreset idle busy", busy, 0);
        do_op(16'd200, 8'd9, lat, bcnt);
        check("after reset latency", lat, 8);
        check("after reset quotient", quotient, 22);
        check("after reset remainder", remainder, 2);

        // Back-to-back: start held high across the done cycle
        @(negedge clk);
        dividend = 16'd1000;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        dividend = 16'd200;
        divisor  = 8'd9;
        wait_done(lat);
        check("b2b first latency", lat, 8);
        check("b2b first quotient", quotient, 142);
        check("b2b first remainder", remainder, 6);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b no busy gap", busy, 1);
        check("b2b done dropped", done, 0);
        wait_done(extra);
        check("b2b second latency", lat + 1 + extra, 17);
        check("b2b second quotient", quotient, 22);
        check("b2b second remainder", remainder, 2);

        // Randomized sweep against a behavioural model
        for (int k = 0; k < 600; k++) begin
            rdv = 8'($urandom_range(0, 255));
            if (k % 8 == 0) rdv = 8'd0;
            rdd = 16'($urandom);
            if (k % 2 == 0 && rdv != 0) rdd[15:8] = 8'($urandom % rdv);
            edz = (rdv == 0);
            eov = !edz && (rdd[15:8] >= rdv);
            if (edz || eov) begin
                eq = 8'hFF;
                er = 8'd0;
                elat = 1;
            end else begin
                eq = 8'(rdd / rdv);
                er = 8'(rdd % rdv);
                elat = 8;
            end
            do_op(rdd, rdv, lat, bcnt);
            check($sformatf("rand%0d %0d/%0d latency", k, rdd, rdv), lat, elat);
            check($sformatf("rand%0d %0d/%0d result", k, rdd, rdv),
                  {14'd0, div_by_zero, overflow, quotient, remainder}, {14'd0, edz, eov, eq, er});
            if (!edz && !eov) begin
                check($sformatf("rand%0d invariant", k),
                      32'(quotient * rdv + remainder), 32'(rdd));
                check($sformatf("rand%0d rem<div", k), remainder < rdv, 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
